// File: rtl/calc_display_defs.sv
// Shared constants for the calculator display logic: segment patterns,
// FSM state encodings and the display range limit.
package calc_display_defs;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } disp_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest magnitude that fits on four decimal digits
  localparam logic [15:0] DISPLAY_MAX = 16'd9999;

  // Number of double-dabble iterations for a 16-bit binary input
  localparam int CONV_ITERS = 16;

  // Active-low one-hot digit enable for a 2-bit digit index
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 never occur on valid BCD and decode to blank.
module seg7_decoder
  import calc_display_defs::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map one BCD digit to its segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display_driver.sv
// Converts a 16-bit signed/unsigned result to BCD with a sequential
// double-dabble and multiplexes it onto a four-digit seven-segment display.
// The displayed value only changes in the single UPDATE cycle, so a reset
// or an aborted conversion can never show a partially converted number.
module result_display_driver
  import calc_display_defs::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] result,
  input  logic        neg,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Magnitude of the incoming result; two's-complement negate when negative
  function automatic logic [15:0] magnitude_of(input logic [15:0] value,
                                               input logic        is_neg);
    logic [15:0] negated;
    negated = ~value + 16'd1;
    return is_neg ? negated : value;
  endfunction

  // Saturation check: anything above four digits shows as dashes
  function automatic logic over_range(input logic [15:0] mag);
    return mag > DISPLAY_MAX;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
  // combined {bcd, binary} register left by one bit.
  function automatic logic [35:0] dabble_step(input logic [19:0] bcd_in,
                                              input logic [15:0] bin_in);
    logic [19:0] adj;
    logic [35:0] joined;
    for (int i = 0; i < 5; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = bcd_in[4*i +: 4];
    end
    joined = {adj, bin_in};
    return joined << 1;
  endfunction

  // Leading-zero blanking: a digit is blank when it and every digit to its
  // left are zero; the rightmost digit always shows.
  function automatic logic digit_blank(input logic [3:0][3:0] digits,
                                       input logic [1:0]      idx);
    logic blank;
    case (idx)
      2'd3:    blank = (digits[3] == 4'd0);
      2'd2:    blank = (digits[3] == 4'd0) && (digits[2] == 4'd0);
      2'd1:    blank = (digits[3] == 4'd0) && (digits[2] == 4'd0) &&
                       (digits[1] == 4'd0);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

  disp_state_t      state;
  disp_state_t      state_nxt;
  logic [3:0]       iter;
  logic             neg_pend;
  logic             ovf_pend;
  logic [15:0]      bin_sh;
  logic [19:0]      bcd_sh;
  logic [15:0]      mag_in;
  logic             start;

  logic [3:0][3:0]  digit_q;
  logic             neg_q;
  logic             ovf_q;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_idx;

  logic [3:0]       cur_bcd;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [3:0]       an_d;

  logic             unused_result_hi;

  // Upper result bits carry nothing for the display
  assign unused_result_hi = ^result[31:16];

  assign mag_in = magnitude_of(result[15:0], neg);
  assign start  = (state == IDLE) && load;
  assign busy   = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state logic; load is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (iter == 4'(CONV_ITERS - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion control: iteration count and the sign/overflow of the value
  // being converted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter     <= 4'd0;
      neg_pend <= 1'b0;
      ovf_pend <= 1'b0;
    end else if (start) begin
      iter     <= 4'd0;
      neg_pend <= neg;
      ovf_pend <= over_range(mag_in);
    end else if (state == CONVERT) begin
      iter     <= iter + 4'd1;
    end
  end

  // Double-dabble shift register; contents are only meaningful in CONVERT
  // and UPDATE, so it needs no reset
  always_ff @(posedge clk) begin
    if (start) begin
      bin_sh <= mag_in;
      bcd_sh <= 20'd0;
    end else if (state == CONVERT) begin
      {bcd_sh, bin_sh} <= dabble_step(bcd_sh, bin_sh);
    end
  end

  // Displayed value: committed atomically in UPDATE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == UPDATE) begin
      digit_q <= bcd_sh[15:0];
      neg_q   <= neg_pend;
      ovf_q   <= ovf_pend;
    end
  end

  // Free-running scan timer and digit index, independent of conversions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  assign cur_bcd = digit_q[digit_idx];

  seg7_decoder u_seg7_decoder (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Pattern for the digit currently being scanned
  always_comb begin
    seg_d = dec_seg;
    if (ovf_q)
      seg_d = SEG_DASH;
    else if (digit_blank(digit_q, digit_idx))
      seg_d = SEG_BLANK;
    dp_d = !((digit_idx == 2'd3) && neg_q);
    an_d = digit_enable(digit_idx);
  end

  // Output registers: an, seg and dp always change together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= SEG_0;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: doc/result_display_driver.md
RESULT_DISPLAY_DRIVER -- requirements
Module: result_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit scan slot.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  one-cycle strobe: capture result/neg and start conversion.
REQ-005 SHALL have port result  input  32  arithmetic-stage output; only bits [15:0] used.
REQ-006 SHALL have port neg  input  1  negative flag from arithmetic stage (1 = result[15:0] is a two's-complement negative).
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port seg  output  7  active-low segments: seg[0]=a through seg[6]=g.
REQ-009 SHALL have port dp  output  1  active-low decimal point.
REQ-010 SHALL have port an  output  4  active-low digit enables; an[0] = rightmost digit.

Function
REQ-011 SHALL, on load while IDLE, latch magnitude = neg ? (~result[15:0] + 1) mod 2^16 : result[15:0], latch neg, and enter CONVERT.
REQ-012 SHALL ignore result[31:16] entirely.
REQ-013 SHALL use FSM states IDLE, CONVERT, UPDATE: IDLE->CONVERT on load; CONVERT->UPDATE after exactly 16 shift-add-3 (double-dabble) iterations; UPDATE->IDLE after one cycle.
REQ-014 SHALL assert busy in CONVERT and UPDATE: busy rises the cycle after load and stays high 17 cycles.
REQ-015 SHALL update the four displayed digit registers in UPDATE only; the previous value stays displayed during conversion.
REQ-016 SHALL ignore load while busy is high; no queueing.
REQ-017 SHALL, when magnitude > 9999, display "----" (seg = 7'b0111111 on all four digits).
REQ-018 SHALL blank leading zeros (seg = 7'b1111111) on digits 3..1; digit 0 is never blanked.
REQ-019 SHALL light dp on digit 3 only, only when the latched neg is 1 (including the overflow "----" case).
REQ-020 SHALL run a free-running scan counter 0..REFRESH_DIV-1; on wrap, advance the digit index 0->1->2->3->0.
REQ-021 SHALL drive an as the active-low one-hot of the digit index, with seg/dp for that digit in the same cycle.
REQ-022 SHALL decode BCD 0-9 to the standard active-low patterns (0 = 7'b1000000, 1 = 7'b1111001, ... 9 = 7'b0010000).
REQ-023 SHALL register seg, dp and an (no combinational path from inputs to outputs).
REQ-024 SHALL not let load or the conversion disturb the scan counter or digit index.

Reset
REQ-025 SHALL, on reset assertion, immediately force: state IDLE, busy 0, digit registers 0, latched neg 0, scan counter 0, digit index 0.
REQ-026 SHALL give reset output values an = 4'b1110, seg = 7'b1000000, dp = 1 (display shows "   0").
REQ-027 SHALL abort any in-progress conversion on reset; no partial value ever reaches the display.

Structure
REQ-028 SHALL take segment patterns (digits 0-9, dash, blank) and FSM state encodings from a shared constants include, calc_display_defs, also used by other calculator display logic.
REQ-029 SHALL instantiate one combinational sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low segments out); conversion, FSM and scan stay in the top module.
REQ-030 SHALL keep REFRESH_DIV overridable so benches can use small values (e.g. 4).

Verification
REQ-031 Reset with REFRESH_DIV=4 -> an=1110, seg=1000000, dp=1, busy=0; an steps 1101, 1011, 0111 every 4 cycles.
REQ-032 load, result=32'd1234, neg=0 -> busy high 17 cycles; then digits 3..0 show 1,2,3,4; dp=1 on all digits.
REQ-033 load, result=32'h0000FFFB, neg=1 -> digits "   5"; dp=0 only while an=0111.
REQ-034 load, result=32'd10000, neg=0 -> all digits seg=0111111; load, result=32'hABCD0007 -> "   7" (upper bits ignored).
REQ-035 load 32'd42, then load 32'd99 five cycles later while busy -> second ignored, "  42" shown; a later load of 99 after busy falls is accepted.
REQ-036 Assert reset eight cycles into a conversion of 32'd8888 -> busy drops immediately and the display shows "   0", never 8888.
